bsg_wormhole_packet_assembler: RTL
==================================

Name: bsg_wormhole_packet_assembler

Overview:
- Ejection stage that sits directly downstream of one wormhole router output port, normally the processor (P) direction.
- Consumes the header and body flits of one wormhole packet from the router's ready/and link.
- Reassembles them into one wide packet register and presents that register to the local client with a valid/yumi handshake.
- Provides backpressure into the router while the client has not yet taken the held packet.

Parameters:
- flit_width_p, 32, width of one flit on the router link.
- cord_width_p, 8, width of the destination coordinate field, located at header bits [cord_width_p-1:0].
- len_width_p, 4, width of the length field, located at header bits [cord_width_p+len_width_p-1:cord_width_p]; the field gives the number of body flits.
- max_body_flits_p, 4, number of body flits that can be stored; must be >=1 and <=2**len_width_p-1.

Ports:
- clk_i, in, 1, clock.
- reset_n_i, in, 1, asynchronous active-low reset.
- link_v_i, in, 1, flit valid from the router.
- link_data_i, in, flit_width_p, flit data from the router.
- link_ready_and_o, out, 1, ready to accept a flit (ready/and handshake).
- pkt_v_o, out, 1, assembled packet is held and valid.
- pkt_header_o, out, flit_width_p, the header flit as received.
- pkt_len_o, out, len_width_p, body length exactly as it appeared in the header.
- pkt_data_o, out, max_body_flits_p*flit_width_p, body flits; flit k is in slice k, and slices that were not written read as 0.
- pkt_trunc_o, out, 1, header length was greater than max_body_flits_p.
- pkt_yumi_i, in, 1, client consumes the packet this cycle; legal only when pkt_v_o=1.
- stat_pkts_o, out, 16, packet counter (see Optional Feature).

Behaviour:
- Reset: reset_n_i low asynchronously forces all of the following. The state machine goes to eHDR, the counter to 0, and the data register, header register and trunc flag to 0. Outputs: pkt_v_o=0, link_ready_and_o=1 after reset, stat_pkts_o=0. Reset asserted mid-packet discards any partial packet; no recovery is attempted.
- Handshake: a flit is accepted in a cycle where link_v_i & link_ready_and_o are both 1. link_ready_and_o is a pure function of state: it is 1 in eHDR and eBODY and 0 in eFULL. There is no combinational path from pkt_yumi_i to link_ready_and_o.
- eHDR:
  - On accepting a flit: capture the header and zero the data register. Set trunc = (len > max_body_flits_p) and reset the counter to 0.
  - If len==0, go to eFULL; otherwise go to eBODY.
- eBODY:
  - Each accepted flit is written to slice cnt only if cnt < max_body_flits_p; otherwise it is dropped, but still consumed.
  - cnt increments on every accepted flit. Its width is len_width_p, and it never wraps because cnt <= len-1.
  - When the accepted flit has cnt==len-1, go to eFULL.
- eFULL:
  - pkt_v_o=1 in this state.
  - pkt_yumi_i=1 returns the machine to eHDR on the next cycle; the next header can therefore be accepted one cycle after yumi.
  - All outputs stay stable until yumi.
- Throughput: at best 1 flit per cycle. The bubble cost per packet is one cycle in eFULL plus whatever the client's yumi latency is.
- Latency: pkt_v_o rises in the cycle after the last flit of the packet is accepted.
- Boundary cases:
  - len==max_body_flits_p: fills every slice; trunc=0.
  - len==2**len_width_p-1 with a smaller max: the first max flits are stored, the rest are drained, and trunc=1.
  - link_v_i held high in eFULL: the flit is not accepted.
  - pkt_yumi_i asserted outside eFULL: an assertion fires and the state is unchanged.

Optional Feature:
- Macro: BSG_PKT_ASM_STATS_EN.
- Defined: stat_pkts_o is a 16-bit counter that increments on every yumi, saturates at 16'hFFFF, and is cleared by reset.
- Not defined: stat_pkts_o is tied to 0 and no counter flops are instantiated.

Decomposition:
- Package bsg_pkt_asm_pkg holds:
  - the state enum {eHDR, eBODY, eFULL};
  - a header-field extraction typedef, parameterised as a struct of {len, cord} at the low bits;
  - localparams for the field offsets.
- One sub-module, bsg_pkt_asm_ctrl, holds the FSM and the body counter. It outputs write_en, write_idx and done to a datapath in the top that contains the header and data registers.

Test Plan:
- Header len=2, cord=8'h05, then body flits 32'hAAAA0001 and 32'hAAAA0002, with link_v_i continuously high → pkt_v_o rises 1 cycle after the 3rd acceptance; slices 0 and 1 hold those flits, slices 2 and 3 read 0, trunc=0.
- Header with len=0 → pkt_v_o=1 in the next cycle; pkt_data_o is all 0.
- Header len=6 with max=4, body flits 1..6 → six body flits accepted; slices hold 1,2,3,4; pkt_len_o=6; trunc=1.
- Packet held with yumi delayed 5 cycles while the next header is already valid → link_ready_and_o=0 for the whole hold, the header is accepted in the cycle after yumi, and outputs are unchanged until yumi.
- reset_n_i pulsed low after the header plus 1 body flit (len=3) → pkt_v_o=0 and link_ready_and_o=1 immediately; the next flit is treated as a header.
- With BSG_PKT_ASM_STATS_EN, 3 packets consumed → stat_pkts_o=3. Without the macro → stat_pkts_o=0 throughout.

Source files
------------

// File: rtl/bsg_pkt_asm_pkg.sv
// Shared state encoding and header field layout for the wormhole packet assembler.
package bsg_pkt_asm_pkg;

  typedef enum logic [1:0] {
    eHDR  = 2'd0,
    eBODY = 2'd1,
    eFULL = 2'd2
  } pkt_asm_state_e;

  localparam int unsigned pkt_cord_width_lp  = 8;
  localparam int unsigned pkt_len_width_lp   = 4;
  localparam int unsigned pkt_cord_offset_lp = 0;
  localparam int unsigned pkt_len_offset_lp  = pkt_cord_offset_lp + pkt_cord_width_lp;

  // Low bits of a header flit: length sits directly above the destination coordinate.
  typedef struct packed {
    logic [pkt_len_width_lp-1:0]  len;
    logic [pkt_cord_width_lp-1:0] cord;
  } pkt_hdr_fields_s;

endpackage

// File: rtl/bsg_pkt_asm_ctrl.sv
// Header/body/full sequencing and body flit counter for the packet assembler.
module bsg_pkt_asm_ctrl
  import bsg_pkt_asm_pkg::*;
#(
  parameter int len_width_p      = 4,
  parameter int max_body_flits_p = 4
)
(
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   link_v,
  input  logic [len_width_p-1:0] len,
  input  logic                   yumi,
  output logic                   ready,
  output logic                   pkt_v,
  output logic                   hdr_en,
  output logic                   write_en,
  output logic [len_width_p-1:0] write_idx,
  output logic                   done
);

  localparam logic [len_width_p-1:0] max_lp = len_width_p'(max_body_flits_p);

  pkt_asm_state_e         state_reg;
  logic [len_width_p-1:0] cnt_reg;
  logic [len_width_p-1:0] len_reg;
  logic                   ready_reg;
  logic                   pkt_v_reg;
  logic                   accept;
  logic                   body_last;

  assign accept    = link_v & ready_reg;
  // len_reg is never 0 while in eBODY, so len_reg-1 cannot underflow here.
  assign body_last = (cnt_reg == (len_reg - len_width_p'(1)));

  assign hdr_en    = accept & (state_reg == eHDR);
  assign write_en  = accept & (state_reg == eBODY) & (cnt_reg < max_lp);
  assign write_idx = cnt_reg;
  assign done      = accept & (((state_reg == eHDR) & (len == '0))
                             | ((state_reg == eBODY) & body_last));

  assign ready = ready_reg;
  assign pkt_v = pkt_v_reg;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg <= eHDR;
      cnt_reg   <= '0;
      len_reg   <= '0;
      ready_reg <= 1'b1;
      pkt_v_reg <= 1'b0;
    end else begin
      case (state_reg)
        eHDR: begin
          if (accept) begin
            cnt_reg <= '0;
            len_reg <= len;
            if (len == '0) begin
              state_reg <= eFULL;
              ready_reg <= 1'b0;
              pkt_v_reg <= 1'b1;
            end else begin
              state_reg <= eBODY;
            end
          end
        end
        eBODY: begin
          if (accept) begin
            cnt_reg <= cnt_reg + len_width_p'(1);
            if (body_last) begin
              state_reg <= eFULL;
              ready_reg <= 1'b0;
              pkt_v_reg <= 1'b1;
            end
          end
        end
        eFULL: begin
          if (yumi) begin
            state_reg <= eHDR;
            ready_reg <= 1'b1;
            pkt_v_reg <= 1'b0;
          end
        end
        default: begin
          state_reg <= eHDR;
          ready_reg <= 1'b1;
          pkt_v_reg <= 1'b0;
        end
      endcase
    end
  end

  yumi_only_when_full: assert property (
    @(posedge clk_i) disable iff (!reset_n_i) yumi |-> (state_reg == eFULL));

endmodule

// File: rtl/bsg_wormhole_packet_assembler.sv
// Reassembles one wormhole packet into a wide register and hands it to the client via valid/yumi.
// Build option: define BSG_PKT_ASM_STATS_EN to enable the saturating consumed-packet counter.
module bsg_wormhole_packet_assembler
  import bsg_pkt_asm_pkg::*;
#(
  parameter int flit_width_p     = 32,
  parameter int cord_width_p     = 8,
  parameter int len_width_p      = 4,
  parameter int max_body_flits_p = 4
)
(
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic                                   link_v_i,
  input  logic [flit_width_p-1:0]                link_data_i,
  output logic                                   link_ready_and_o,
  output logic                                   pkt_v_o,
  output logic [flit_width_p-1:0]                pkt_header_o,
  output logic [len_width_p-1:0]                 pkt_len_o,
  output logic [max_body_flits_p*flit_width_p-1:0] pkt_data_o,
  output logic                                   pkt_trunc_o,
  input  logic                                   pkt_yumi_i,
  output logic [15:0]                            stat_pkts_o
);

  localparam int len_offset_lp = int'(pkt_cord_offset_lp) + cord_width_p;
  localparam logic [len_width_p-1:0] max_lp = len_width_p'(max_body_flits_p);

  logic [len_width_p-1:0]  hdr_len;
  logic                    hdr_en;
  logic                    write_en;
  logic [len_width_p-1:0]  write_idx;
  logic                    done;
  logic [flit_width_p-1:0] hdr_reg;
  logic                    trunc_reg;

  assign hdr_len = link_data_i[len_offset_lp +: len_width_p];

  bsg_pkt_asm_ctrl #(
    .len_width_p      (len_width_p),
    .max_body_flits_p (max_body_flits_p)
  ) ctrl (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .link_v    (link_v_i),
    .len       (hdr_len),
    .yumi      (pkt_yumi_i),
    .ready     (link_ready_and_o),
    .pkt_v     (pkt_v_o),
    .hdr_en    (hdr_en),
    .write_en  (write_en),
    .write_idx (write_idx),
    .done      (done)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      hdr_reg   <= '0;
      trunc_reg <= 1'b0;
    end else if (hdr_en) begin
      hdr_reg   <= link_data_i;
      trunc_reg <= (hdr_len > max_lp);
    end
  end

  // A new header clears every slice so unwritten slices of a short packet read as zero.
  for (genvar gi = 0; gi < max_body_flits_p; gi++) begin : g_slice
    logic [flit_width_p-1:0] slice_reg;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        slice_reg <= '0;
      end else if (hdr_en) begin
        slice_reg <= '0;
      end else if (write_en && (write_idx == len_width_p'(gi))) begin
        slice_reg <= link_data_i;
      end
    end

    assign pkt_data_o[gi*flit_width_p +: flit_width_p] = slice_reg;
  end

  assign pkt_header_o = hdr_reg;
  assign pkt_len_o    = hdr_reg[len_offset_lp +: len_width_p];
  assign pkt_trunc_o  = trunc_reg;

`ifdef BSG_PKT_ASM_STATS_EN
  logic [15:0] stat_reg;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stat_reg <= '0;
    end else if (pkt_yumi_i && pkt_v_o && (stat_reg != 16'hFFFF)) begin
      stat_reg <= stat_reg + 16'd1;
    end
  end

  assign stat_pkts_o = stat_reg;
`else
  assign stat_pkts_o = 16'h0000;
`endif

  done_then_valid: assert property (
    @(posedge clk_i) disable iff (!reset_n_i) done |=> pkt_v_o);

endmodule
